// File: rtl/bit_serial_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bsa_state_e;

    localparam int BSA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serial_add_ctrl_fa_slice.sv
// One-bit full-adder slice, purely combinational.
module fa_slice
    import bit_serial_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | ((a | b) & ci);

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder, LSB first; done pulses WIDTH+1 edges after start, start ignored while busy.
// SERIAL_ADDSUB_EN adds a sub input selecting a-b (two's complement via ~b and carry-in 1).
module bit_serial_add_ctrl
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = BSA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDSUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    bsa_state_e       state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    fa_slice u_fa (
        .a  (sha_q[0]),
        .b  (shb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

`ifdef SERIAL_ADDSUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sha_d   = a;
                    shb_d   = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                carry_d = fa_co;
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                // Only the completed result reaches sum; partials stay in res_q.
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_co;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Directed-vector bench for bit_serial_add_ctrl with hand-computed results.
module tb_bit_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cin   = 1'b0;
    logic             sub   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic             cout;
    logic [WIDTH-1:0] sum;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDSUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation, scrambles the operand inputs after capture and
    // optionally pulses start again at RUN cycle restart_at (must be ignored).
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic icin, input logic isub,
                          input logic [7:0] exp_sum, input logic exp_cout,
                          input logic [7:0] prev_sum, input int restart_at);
        int   n;
        int   busy_cnt;
        logic held_bad;
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        tick();
        start = 1'b0; a = ~ia; b = ~ib; cin = ~icin; sub = ~isub;
        chk({tag, "_busy_first"}, busy, 1);
        chk({tag, "_done_first"}, done, 0);
        n = 0; busy_cnt = 0; held_bad = 1'b0;
        while (!done && n < WIDTH + 4) begin
            if (busy) busy_cnt++;
            if (sum !== prev_sum) held_bad = 1'b1;
            start = (n == restart_at);
            if (start) begin a = '1; b = '1; end
            tick();
            n++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, n, WIDTH);
        chk({tag, "_busy_cycles"}, busy_cnt, WIDTH);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_sum"}, sum, exp_sum);
        chk({tag, "_cout"}, cout, exp_cout);
        chk({tag, "_sum_held"}, held_bad, 0);
    endtask

    initial begin
        bit seen;

        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 8'h00, -1);
        tick();
        chk("pulse_done_low", done, 0);
        chk("pulse_sum_held", sum, 8'h96);

        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h96, -1);
        tick();
        run_op("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, -1);
        tick();
        run_op("add_00_00_c", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 8'h00, -1);
        tick();

        run_op("ignore_start", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 8'h01, 3);
        run_op("back_to_back", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 8'h46, -1);
        tick();
        chk("b2b_done_low", done, 0);
        chk("b2b_sum_held", sum, 8'h00);
        chk("b2b_cout_held", cout, 1);

        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("mid_run_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);

        run_op("post_reset", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 8'h00, -1);
        tick();

`ifdef SERIAL_ADDSUB_EN
        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 8'h03, -1);
        tick();
        run_op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h0F, -1);
        tick();
        run_op("nosub_01_02_c", 8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0, 8'hFF, -1);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
